pc_sequencer: RTL

//  Next-PC controller for the interrupt-capable pipelined CPU. Drives the

---
 rtl/pc_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC select (seq/branch/jump/interrupt/eret); owns EPC, interrupt enable and entry FSM.
// Latency: new_pc/pc_write/flush_if are combinational; state, epc, ie and int_ack update on the next clk.
// Backpressure: stall holds the PC in RUN/ENTER/HANDLER; the DRAIN countdown runs regardless of stall.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC    = 32'h0000_3000,
  parameter logic [31:0] HANDLER_VEC  = 32'h0000_4180,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_addr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        int_req,
  input  logic        int_mask,
  input  logic        eret,
  output logic [31:0] new_pc,
  output logic        pc_write,
  output logic        flush_if,
  output logic        int_ack,
  output logic [31:0] epc_out,
  output logic        in_handler
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_ENTER   = 2'd2,
    ST_HANDLER = 2'd3
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t      state, state_nxt;
  logic [31:0] epc, epc_nxt;
  logic        ie, ie_nxt;
  logic [2:0]  drain_cnt, drain_nxt;
  logic        ack_nxt;

  logic [31:0] seq_pc;
  logic [31:0] redir_pc;
  logic        take;

  assign seq_pc   = pc_addr + 32'd4;
  assign redir_pc = jump ? jump_target : (branch_taken ? branch_target : seq_pc);
  assign take     = int_req & int_mask & ie & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      epc       <= RESET_VEC;
      ie        <= 1'b1;
      drain_cnt <= 3'd0;
      int_ack   <= 1'b0;
    end else begin
      state     <= state_nxt;
      epc       <= epc_nxt;
      ie        <= ie_nxt;
      drain_cnt <= drain_nxt;
      int_ack   <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    epc_nxt   = epc;
    ie_nxt    = ie;
    drain_nxt = drain_cnt;
    ack_nxt   = 1'b0;
    new_pc    = redir_pc;
    pc_write  = 1'b0;
    flush_if  = 1'b0;

    case (state)
      ST_RUN: begin
        if (take) begin
          // The redirect resolved in this cycle becomes the return address.
          epc_nxt   = redir_pc;
          ie_nxt    = 1'b0;
          drain_nxt = DRAIN_LOAD;
          flush_if  = 1'b1;
          state_nxt = ST_DRAIN;
        end else begin
          pc_write = ~stall;
          flush_if = ~stall & (jump | branch_taken);
        end
      end
      ST_DRAIN: begin
        flush_if = 1'b1;
        if (drain_cnt == 3'd0) begin
          state_nxt = ST_ENTER;
        end else begin
          drain_nxt = drain_cnt - 3'd1;
        end
      end
      ST_ENTER: begin
        flush_if = 1'b1;
        new_pc   = HANDLER_VEC;
        if (!stall) begin
          pc_write  = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (eret && !stall) begin
          new_pc    = epc;
          pc_write  = 1'b1;
          flush_if  = 1'b1;
          ie_nxt    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          pc_write = ~stall;
          flush_if = ~stall & (jump | branch_taken);
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    if (!rst_n) begin
      new_pc   = RESET_VEC;
      pc_write = 1'b0;
      flush_if = 1'b0;
    end
  end

  assign epc_out    = epc;
  assign in_handler = (state == ST_ENTER) || (state == ST_HANDLER);

endmodule
